serial_alu_seq: RTL and testbench



---
 rtl/serial_alu_seq.sv | 149 ++++++++++++++
 tb/tb_serial_alu_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: drives a one-bit ALU slice across a WIDTH-bit operand,
// one bit per clock, LSB first. The slice's result bits, final carry and
// MSB set are collected into a WIDTH-bit result. SLT uses one extra FIX
// cycle to re-run bit 0 with less = set from the MSB step.
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_less,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout,
  input  logic             alu_set
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              carry_q, carry_d;   // ripple carry between bit steps
  logic              set_q, set_d;       // slice set captured at the MSB step
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;     // final carry, frozen after the MSB step
  logic              busy_q, done_q;

  // Next-state logic and slice drive; slice outputs feed back combinationally
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    set_d    = set_q;
    result_d = result_q;
    cout_d   = cout_q;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    alu_cin  = 1'b0;
    alu_less = 1'b0;
    alu_op   = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          op_d     = op_in;
          idx_d    = {IW{1'b0}};
          carry_d  = op_in[2];          // +1 of the two's complement for SUB/SLT
          result_d = {WIDTH{1'b0}};
          cout_d   = 1'b0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        alu_a            = a_q[idx_q];
        alu_b            = b_q[idx_q];
        alu_cin          = carry_q;
        alu_less         = 1'b0;
        result_d[idx_q]  = alu_result;
        carry_d          = alu_cout;
        if (idx_q == LAST_IDX) begin
          // Index saturates here so it never wraps into a second pass
          set_d   = alu_set;
          cout_d  = alu_cout;
          state_d = (op_q[1:0] == 2'b11) ? S_FIX : S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      S_FIX: begin
        alu_a       = a_q[0];
        alu_b       = b_q[0];
        alu_cin     = op_q[2];
        alu_less    = set_q;
        result_d[0] = alu_result;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= {IW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 3'b000;
      carry_q  <= 1'b0;
      set_q    <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      set_q    <= set_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= (state_d == S_RUN) || (state_d == S_FIX);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = result_q;
  assign carry_out  = cout_q;
  assign zero_out   = (result_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq (WIDTH=8) with a one-bit ALU slice
// modelled in the bench and a word-level arithmetic reference model.
module tb_serial_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op_in;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, carry_out, zero_out;
  logic [W-1:0] result_out;
  logic         alu_a, alu_b, alu_cin, alu_less;
  logic [2:0]   alu_op;
  logic         alu_result, alu_cout, alu_set;

  int n_tests = 0;
  int n_fail  = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result_out(result_out), .carry_out(carry_out),
    .zero_out(zero_out), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_less(alu_less), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout), .alu_set(alu_set)
  );

  always #5 clk = ~clk;

  // One-bit ALU slice: binv inverts b; 00 AND, 01 OR, 10 sum, 11 less
  logic slice_bb, slice_sum;
  always_comb begin
    slice_bb  = alu_b ^ alu_op[2];
    slice_sum = alu_a ^ slice_bb ^ alu_cin;
    alu_cout  = (alu_a & slice_bb) | (alu_a & alu_cin) | (slice_bb & alu_cin);
    alu_set   = slice_sum;
    case (alu_op[1:0])
      2'b00:   alu_result = alu_a & slice_bb;
      2'b01:   alu_result = alu_a | slice_bb;
      2'b10:   alu_result = slice_sum;
      default: alu_result = alu_less;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: returns {carry, result}
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] op);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] r;
    bb   = op[2] ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[2]};
    case (op[1:0])
      2'b00:   r = a & bb;
      2'b01:   r = a | bb;
      2'b10:   r = full[W-1:0];
      default: r = {{(W-1){1'b0}}, full[W-1]};
    endcase
    return {full[W], r};
  endfunction

  // Run one operation; optionally disturb start/inputs while busy
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input bit disturb, input string tag);
    logic [W:0] exp;
    int lat;
    int bad_busy;
    exp = model(a, b, op);
    @(negedge clk);
    a_in = a; b_in = b; op_in = op; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); op_in = 3'($urandom);
    lat = 0;
    bad_busy = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy !== 1'b1) bad_busy++;
      if (disturb) begin
        start = 1'($urandom);
        a_in = W'($urandom); b_in = W'($urandom); op_in = 3'($urandom);
      end
      if (lat > 20) break;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, (op[1:0] == 2'b11) ? W + 2 : W + 1);
    check({tag, " busy"}, bad_busy, 0);
    check({tag, " result"}, result_out, exp[W-1:0]);
    check({tag, " carry"}, carry_out, exp[W]);
    check({tag, " zero"}, zero_out, (exp[W-1:0] == '0));
    @(negedge clk);
    check({tag, " idle"}, {done, busy, alu_a, alu_b, alu_cin, alu_less}, 0);
    check({tag, " idle op"}, alu_op, op);
    check({tag, " hold"}, result_out, exp[W-1:0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ctl"}, {busy, done, carry_out, zero_out}, 4'b0001);
    check({tag, " result"}, result_out, 0);
    check({tag, " alu"}, {alu_a, alu_b, alu_cin, alu_less, alu_op}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_in = 3'b000; a_in = '0; b_in = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h7F, 8'h01, 3'b010, 1'b0, "add");
    run_op(8'h05, 8'h05, 3'b110, 1'b0, "sub");
    run_op(8'hFE, 8'h03, 3'b111, 1'b0, "slt");
    run_op(8'h03, 8'hFE, 3'b111, 1'b0, "slt_swap");
    run_op(8'hC3, 8'h5A, 3'b000, 1'b0, "and");
    run_op(8'hC3, 8'h5A, 3'b001, 1'b0, "or");
    run_op(8'h12, 8'h34, 3'b010, 1'b1, "add_busy_start");
    run_op(8'h80, 8'h7F, 3'b111, 1'b1, "slt_busy_start");

    // Asynchronous reset in the middle of an ADD
    @(negedge clk);
    a_in = 8'h55; b_in = 8'h66; op_in = 3'b010; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h10, 8'h20, 3'b010, 1'b0, "add_after_reset");

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
